// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and helpers for the 1-to-N stream demux
package demux_pkg;

    localparam logic MODE_UNICAST = 1'b0;
    localparam logic MODE_BCAST   = 1'b1;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output register with zero-on-empty data
module demux_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             free_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // A load wins over a drain in the same cycle, keeping one word per cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = load_data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
            data_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/demux_1ton_stream.sv
// rtl/demux_1ton_stream.sv - registered 1-to-N valid/ready demux with broadcast and drop counter
module demux_1ton_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int SEL_W = sel_width(N),
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_bcast,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]   drop_cnt
);

    logic [N-1:0]     free;
    logic [N-1:0]     load;
    logic             in_range;
    logic             sel_free;
    logic             accept;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        in_range = (32'(in_sel) < 32'(N));
        sel_free = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (32'(in_sel) == 32'(k)) begin
                sel_free = free[k];
            end
        end
        // Out-of-range unicast is always taken so it can be counted and discarded.
        if (in_bcast == MODE_BCAST) begin
            in_ready = &free;
        end else if (in_range) begin
            in_ready = sel_free;
        end else begin
            in_ready = 1'b1;
        end
        if (rst) begin
            in_ready = 1'b0;
        end
        accept = in_valid && in_ready;
    end

    always_comb begin
        load = '0;
        for (int k = 0; k < N; k++) begin
            load[k] = accept && ((in_bcast == MODE_BCAST) || (32'(in_sel) == 32'(k)));
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (accept && (in_bcast == MODE_UNICAST) && !in_range) begin
            drop_cnt_d = CNT_W'(sat_inc(32'(drop_cnt_q), CNT_W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;

    for (genvar k = 0; k < N; k++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk_i      (clk),
            .rst_i      (rst),
            .load_i     (load[k]),
            .load_data_i(in_data),
            .ready_i    (out_ready[k]),
            .valid_o    (out_valid[k]),
            .data_o     (out_data[k*WIDTH +: WIDTH]),
            .free_o     (free[k])
        );
    end

endmodule

// File: tb/tb_demux_1ton_stream.sv
// tb/tb_demux_1ton_stream.sv - self-checking bench for demux_1ton_stream
module tb_demux_1ton_stream;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int NB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, in_valid, in_ready, in_bcast;
    logic [1:0]     in_sel;
    logic [W-1:0]   in_data;
    logic [N-1:0]   out_valid, out_ready;
    logic [N*W-1:0] out_data;
    logic [7:0]     drop_cnt;

    logic            b_rst, b_in_valid, b_in_ready, b_in_bcast;
    logic [1:0]      b_in_sel;
    logic [W-1:0]    b_in_data;
    logic [NB-1:0]   b_out_valid, b_out_ready;
    logic [NB*W-1:0] b_out_data;
    logic [7:0]      b_drop_cnt;

    demux_1ton_stream #(.WIDTH(W), .N(N), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .drop_cnt(drop_cnt)
    );

    demux_1ton_stream #(.WIDTH(W), .N(NB), .CNT_W(8)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_sel(b_in_sel), .in_bcast(b_in_bcast),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .drop_cnt(b_drop_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: slot contents as plain arrays, advanced once per cycle.
    logic [N-1:0] mv;
    logic [W-1:0] md [N];
    int           mdrop;
    bit           mon = 1'b0;

    always @(negedge clk) begin
        logic [63:0] exp_data;
        bit          all_free, rdy, acc, hit;
        bit          fr [N];
        for (int k = 0; k < N; k++) fr[k] = !mv[k] || out_ready[k];
        all_free = 1'b1;
        for (int k = 0; k < N; k++) all_free = all_free && fr[k];
        if (in_bcast) rdy = all_free;
        else if (int'(in_sel) < N) rdy = fr[in_sel];
        else rdy = 1'b1;
        if (rst) rdy = 1'b0;
        if (mon) begin
            exp_data = '0;
            for (int k = 0; k < N; k++) exp_data[k*W +: W] = mv[k] ? md[k] : '0;
            chk("model_out_valid", 64'(out_valid), 64'(mv));
            chk("model_out_data", 64'(out_data), exp_data);
            chk("model_drop_cnt", 64'(drop_cnt), 64'(mdrop));
            chk("model_in_ready", 64'(in_ready), 64'(rdy));
        end
        if (rst) begin
            mv <= '0;
            for (int k = 0; k < N; k++) md[k] <= '0;
            mdrop <= 0;
            mon <= 1'b1;
        end else if (mon) begin
            acc = in_valid && rdy;
            for (int k = 0; k < N; k++) begin
                hit = acc && (in_bcast || int'(in_sel) == k);
                if (hit) begin
                    mv[k] <= 1'b1;
                    md[k] <= in_data;
                end else if (mv[k] && out_ready[k]) begin
                    mv[k] <= 1'b0;
                    md[k] <= '0;
                end
            end
            if (acc && !in_bcast && int'(in_sel) >= N) mdrop <= (mdrop >= 255) ? 255 : mdrop + 1;
        end
    end

    initial begin
        bit r;
        rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_bcast = 1'b0; in_data = '0; out_ready = '0;
        b_rst = 1'b1; b_in_valid = 1'b0; b_in_sel = '0; b_in_bcast = 1'b0; b_in_data = '0; b_out_ready = '0;

        tick();
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);

        // single unicast to channel 2
        tick();
        in_valid = 1'b1; in_sel = 2'd2; in_data = 16'hA5A5;
        @(negedge clk);
        chk("uni_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("uni_out_valid", 64'(out_valid), 64'h4);
        chk("uni_out_data", 64'(out_data), 64'h0000_A5A5_0000_0000);

        // backpressure isolation
        tick();
        in_valid = 1'b1; in_sel = 2'd1; in_data = 16'h0001;
        tick();
        in_data = 16'h0002;
        @(negedge clk);
        chk("bp_blocked", 64'(in_ready), 64'd0);
        tick();
        in_sel = 2'd3; in_data = 16'h0003;
        @(negedge clk);
        chk("bp_other_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_out_valid", 64'(out_valid), 64'hE);
        chk("bp_out_data", 64'(out_data), 64'h0003_A5A5_0001_0000);

        // streaming 1..8 into channel 0
        tick();
        out_ready = 4'b0001; in_sel = 2'd0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 16'(i);
            @(negedge clk);
            chk("stream_in_ready", 64'(in_ready), 64'd1);
            if (i > 1) chk("stream_slice0", 64'(out_data[15:0]), 64'(i - 1));
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_last", 64'(out_data[15:0]), 64'd8);
        tick();

        // broadcast blocked by full channel 2
        out_ready = 4'b1010;
        tick();
        out_ready = 4'b0000;
        in_valid = 1'b1; in_bcast = 1'b1; in_data = 16'hBEEF;
        @(negedge clk);
        chk("bc_blocked0", 64'(in_ready), 64'd0);
        tick();
        @(negedge clk);
        chk("bc_blocked1", 64'(in_ready), 64'd0);
        tick();
        out_ready = 4'b0100;
        @(negedge clk);
        chk("bc_ready", 64'(in_ready), 64'd1);
        tick();
        out_ready = 4'b0000; in_valid = 1'b0; in_bcast = 1'b0;
        @(negedge clk);
        chk("bc_out_valid", 64'(out_valid), 64'hF);
        chk("bc_out_data", 64'(out_data), 64'hBEEF_BEEF_BEEF_BEEF);

        // reset mid-stream with out_valid=1011
        tick();
        out_ready = 4'b0100;
        tick();
        out_ready = 4'b0000;
        @(negedge clk);
        chk("mid_pre_valid", 64'(out_valid), 64'hB);
        tick();
        rst = 1'b1; in_valid = 1'b1; in_sel = 2'd2; in_data = 16'h1234;
        @(negedge clk);
        chk("mid_in_ready", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("mid_out_valid", 64'(out_valid), 64'd0);
        chk("mid_out_data", 64'(out_data), 64'd0);

        // randomized traffic, holding a stalled word stable
        r = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!(in_valid && !r) || rst) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_bcast = ($urandom_range(0, 5) == 0);
                in_sel   = 2'($urandom_range(0, 3));
                in_data  = 16'($urandom);
            end
            out_ready = 4'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            r = in_ready;
        end
        tick();
        rst = 1'b0; in_valid = 1'b0;

        // N=3 instance: out-of-range drops and saturation
        b_rst = 1'b0;
        @(negedge clk);
        chk("b_rst_drop", 64'(b_drop_cnt), 64'd0);
        tick();
        b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b_drop_ready", 64'(b_in_ready), 64'd1);
            tick();
        end
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("b_drop_valid", 64'(b_out_valid), 64'd0);
        chk("b_drop_data", 64'(b_out_data), 64'd0);
        chk("b_drop_cnt3", 64'(b_drop_cnt), 64'd3);
        tick();
        b_in_valid = 1'b1;
        for (int i = 0; i < 297; i++) tick();
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("b_drop_sat", 64'(b_drop_cnt), 64'd255);
        tick();
        b_in_valid = 1'b1; b_in_sel = 2'd2; b_in_data = 16'h0007;
        tick();
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("b_uni_valid", 64'(b_out_valid), 64'h4);
        chk("b_uni_data", 64'(b_out_data), 64'h0007_0000_0000);
        chk("b_sat_hold", 64'(b_drop_cnt), 64'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
